// File: rtl/mix_sequencer.sv
// mix_sequencer
//   Splits one input block plus its domain separator into NCH chunks of
//   2*CW bits and issues them one per consumer handshake, chunk 0 first.
//   Each chunk is a mix index word: bits [2i+1:2i] pick the 32-bit input
//   word that gets XORed into capacity word i.
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst       asynchronous active-high reset
//   in_data   block to be mixed (INW bits)
//   in_ds     domain separator (DSW bits)
//   in_valid  in_data/in_ds valid
//   in_ready  block accepted when in_valid && in_ready (IDLE only)
//   d_out     current mix index word (2*CW bits)
//   d_valid   d_out valid
//   d_ready   consumer accepts d_out
//   d_last    d_out is the final chunk of the block
//   busy      a block is being issued
module mix_sequencer #(
  parameter int CW  = 5,
  parameter int INW = 128,
  parameter int DSW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [INW-1:0]  in_data,
  input  logic [DSW-1:0]  in_ds,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [2*CW-1:0] d_out,
  output logic            d_valid,
  input  logic            d_ready,
  output logic            d_last,
  output logic            busy
);

  localparam int DW   = 2 * CW;
  localparam int NCH  = (INW + DSW + DW - 1) / DW;
  localparam int SRW  = NCH * DW;
  localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNTW-1:0] LAST_CHUNK = CNTW'(NCH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]      r_state;
  logic [SRW-1:0]  r_shift;
  logic [CNTW-1:0] r_cnt;

  logic [SRW-1:0]  w_load;
  logic            w_load_en;
  logic            w_advance;
  logic            w_at_last;

  // Block image: data in the low bits, separator above it, zero pad on top
  // so the last chunk is always fully defined.
  always_comb begin
    w_load                = '0;
    w_load[INW+DSW-1:0]   = {in_ds, in_data};
  end

  assign w_load_en = (r_state == S_IDLE) && in_valid;
  assign w_advance = (r_state == S_ISSUE) && d_ready;
  assign w_at_last = (r_cnt == LAST_CHUNK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load_en) begin
            r_shift <= w_load;
            r_cnt   <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Under a stall nothing moves, so the presented chunk is held.
          if (w_advance) begin
            r_shift <= r_shift >> DW;
            if (w_at_last) begin
              // Shift register is all-zero after the last chunk leaves,
              // so d_out idles at zero between blocks.
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CNTW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready = (r_state == S_IDLE);
  assign d_valid  = (r_state == S_ISSUE);
  assign busy     = (r_state == S_ISSUE);
  assign d_out    = r_shift[DW-1:0];
  assign d_last   = (r_state == S_ISSUE) && w_at_last;

endmodule

// File: tb/tb_mix_sequencer.sv
// Testbench for mix_sequencer (default parameters).
// Stimulus side pushes the expected chunk sequence of every accepted block
// into a queue; the monitor compares presented words against the queue
// head and pops on each consumer handshake.
module tb_mix_sequencer;

  localparam int NCH = 14;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] in_data = '0;
  logic [3:0]   in_ds = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [9:0]   d_out;
  logic         d_valid;
  logic         d_ready = 1'b1;
  logic         d_last;
  logic         busy;

  mix_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_ds    (in_ds),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d_out    (d_out),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_last   (d_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] data;
    logic       last;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_count = 0;
  int   hs_count = 0;
  bit   rmode = 1'b0;
  bit   mon_active;
  int   mon_idx;

  // Reference: chunk k is bits [10k+9:10k] of {pad, ds, data}.
  function automatic logic [9:0] model_chunk(input logic [127:0] d,
                                             input logic [3:0] ds,
                                             input int k);
    logic [139:0] blk;
    blk = {8'h00, ds, d};
    blk = blk >> (10 * k);
    return blk[9:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: everything sampled on the falling edge, where
  // inputs (driven at posedge+1) and outputs are both settled.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      mon_active = (sb_q.size() != 0);
      check("in_ready", in_ready, !mon_active);
      check("d_valid", d_valid, mon_active);
      check("busy", busy, mon_active);
      if (mon_active) begin
        check("d_out", d_out, sb_q[0].data);
        check("d_last", d_last, sb_q[0].last);
        if (d_ready) begin
          mon_idx = NCH - sb_q.size();
          $display("chunk %0d d_out=0x%03h last=%0b", mon_idx, d_out, d_last);
          void'(sb_q.pop_front());
          hs_count++;
        end
      end else if (in_valid) begin
        for (int k = 0; k < NCH; k++)
          sb_q.push_back('{data: model_chunk(in_data, in_ds, k), last: (k == NCH - 1)});
        acc_count++;
        $display("accept block data=0x%032h ds=0x%0h", in_data, in_ds);
      end
    end
  end

  // Consumer back-pressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      d_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [127:0] d, input logic [3:0] ds);
    int base;
    int n;
    base = acc_count;
    n = 0;
    in_data  = d;
    in_ds    = ds;
    in_valid = 1'b1;
    while (acc_count == base && n < 100) begin
      wait_cycle();
      n++;
    end
    check("accept_timeout", 32'(acc_count != base), 1);
    in_valid = 1'b0;
    // Changing inputs during issue must not disturb the block in flight.
    in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_ds   = 4'($urandom());
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      wait_cycle();
      n++;
    end
    check("drain_timeout", 32'(sb_q.size()), 0);
    wait_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_valid"}, d_valid, 0);
    check({tag, "_d_last"}, d_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_d_out"}, d_out, 0);
  endtask

  initial begin
    int base;
    int n;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (3) wait_cycle();
    rst = 1'b0;
    wait_cycle();

    // Single low chunk, always ready.
    rmode = 1'b0;
    send_block(128'h3FF, 4'h0);
    wait_idle();

    // Separator only: lands in chunks 12 and 13.
    send_block(128'h0, 4'hF);
    wait_idle();

    // Fixed pattern with random back-pressure.
    rmode = 1'b1;
    send_block(128'h0123456789ABCDEF_FEDCBA9876543210, 4'h5);
    wait_idle();

    // Random blocks, random back-pressure.
    for (int b = 0; b < 20; b++) begin
      send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 4'($urandom()));
      if (b % 3 == 0) wait_idle();
    end
    wait_idle();

    // Reset in the middle of a block, right after chunk 5 is accepted.
    rmode = 1'b0;
    base = hs_count;
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 4'hA);
    n = 0;
    while (hs_count < base + 6 && n < 100) begin
      wait_cycle();
      n++;
    end
    check("mid_block_timeout", 32'(hs_count >= base + 6), 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    wait_cycle();
    wait_cycle();
    rst = 1'b0;
    wait_cycle();
    check_reset_outputs("post_reset");
    send_block(128'hFFFF_0000_AAAA_5555_1234_5678_9ABC_DEF0, 4'h3);
    wait_idle();

    // in_valid held high with data changing every cycle.
    rmode = 1'b1;
    base = acc_count;
    in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_ds   = 4'($urandom());
      wait_cycle();
    end
    in_valid = 1'b0;
    wait_idle();
    check("held_valid_blocks", 32'(acc_count - base >= 2), 1);

    check("final_queue_empty", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
